mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter between the per-core caches (cache_mem_if, master side) and the single main memory port.
- Serialises one byte transaction at a time.
- Broadcasts every granted access on the snoop bus (snoop_if driver) one cycle before it reaches memory, so peer caches can invalidate or downgrade their copies.
- Sits directly downstream of the caches and upstream of main memory.

Parameters:
- N_CORES, 4, number of cache requesters; max 4 (snoop_core is 2 bits).
- ADDR_W, 11, byte address width (system_widths_pkg).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- c_req_valid  input  N_CORES  per-core request pending (cache_mem_if mem_req_valid)
- c_req_we  input  N_CORES  per-core 0=read, 1=write
- c_req_addr  input  N_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
- c_req_write  input  N_CORES*8  per-core write byte
- c_req_ready  output  N_CORES  per-core accept pulse
- c_resp_valid  output  N_CORES  per-core completion pulse
- c_resp_data  output  8  read byte, shared by all cores, qualified by c_resp_valid[i]
- m_req_valid  output  1  request to main memory
- m_req_ready  input  1  memory accepts request
- m_req_we  output  1  0=read, 1=write
- m_req_addr  output  ADDR_W  memory address
- m_req_write  output  8  memory write byte
- m_resp_valid  input  1  memory response / write done
- m_resp_data  input  8  memory read byte
- snoop_valid  output  1  snoop broadcast this cycle
- snoop_core  output  2  initiating core index
- snoop_cmd  output  1  0=read, 1=RFO (write)
- snoop_addr  output  ADDR_W  snooped address

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - All outputs are 0.
  - last_grant = N_CORES-1, so core 0 has top priority first.
  - Latched request fields are cleared.
  - Reset mid-transaction abandons it: no c_resp_valid is issued. Memory is reset by the same rst_n.
- IDLE:
  - If any c_req_valid is set, select the first asserted index searching from last_grant+1 upward, wrapping modulo N_CORES.
  - Latch grant, we, addr and write byte.
  - Pulse c_req_ready[grant]=1 for exactly this cycle. The cache drops or advances its request on that cycle.
  - Go to SNOOP.
  - With no valid request, stay in IDLE.
- SNOOP (exactly 1 cycle):
  - snoop_valid=1, snoop_core=grant, snoop_cmd=latched we, snoop_addr=latched addr.
  - Go to ISSUE.
- ISSUE:
  - m_req_valid=1 with latched we/addr/write.
  - Fields are held stable until m_req_ready=1; at that point go to WAIT.
  - If m_resp_valid is also 1 in that same cycle, complete immediately (same actions as WAIT completion).
- WAIT:
  - m_req_valid=0.
  - On m_resp_valid=1: c_resp_valid[grant]=1 for one cycle, c_resp_data=m_resp_data (registered, same cycle as the pulse), last_grant=grant, go to IDLE.
  - Writes also complete on m_resp_valid; data is don't-care.
- Output timing and gating:
  - c_resp_data holds its last value otherwise.
  - c_req_ready and c_resp_valid are one-hot or zero.
  - m_resp_valid outside ISSUE/WAIT is ignored.
- Latency: accept at cycle T, snoop at T+1, m_req_valid from T+2. Best-case response to the cache is at T+3 (memory ready and response both at T+2, response registered).
- Fairness:
  - A core that has just been served has lowest priority next.
  - Each continuously requesting core is served within N_CORES transactions.
- Back-to-back: after completion the FSM returns to IDLE for 1 cycle before the next accept. Minimum 4 cycles per transaction.
- Request changes: changes on c_req_* of a non-granted core are never seen mid-transaction.

Test Plan:
- Single read: core 2 reads addr 0x155; memory returns ready at once and 0xA5 two cycles later. Expect c_req_ready[2] pulse, then snoop (core=2, cmd=0, addr=0x155), then m_req_valid with addr 0x155, then c_resp_valid[2] with data 0xA5. No other bits toggle.
- Write RFO: core 1 writes 0x3C to 0x7FF. Expect snoop_cmd=1, m_req_we=1, m_req_write=0x3C, then c_resp_valid[1] after m_resp_valid.
- Round-robin: cores 0–3 hold requests continuously. Expect grant order 0,1,2,3,0; in each case the served core waits 3 other grants before being served again.
- Backpressure: m_req_ready held low 5 cycles. m_req_valid/addr/we/write stay stable; exactly one memory handshake occurs; no duplicate snoop.
- Same-cycle ready+resp: m_req_ready and m_resp_valid both 1 in ISSUE. Expect a single c_resp_valid pulse on the next cycle and FSM in IDLE.
- Reset in WAIT: rst_n low while waiting. All outputs go to 0 asynchronously. After release, core 0 request is granted before a simultaneous core 3 request, and no stale c_resp_valid appears.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - cache-side, memory-side and snoop signals of the memory bus arbiter
interface mem_bus_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 11
);
  logic [N_CORES-1:0]        c_req_valid;
  logic [N_CORES-1:0]        c_req_we;
  logic [N_CORES*ADDR_W-1:0] c_req_addr;
  logic [N_CORES*8-1:0]      c_req_write;
  logic [N_CORES-1:0]        c_req_ready;
  logic [N_CORES-1:0]        c_resp_valid;
  logic [7:0]                c_resp_data;

  logic                      m_req_valid;
  logic                      m_req_ready;
  logic                      m_req_we;
  logic [ADDR_W-1:0]         m_req_addr;
  logic [7:0]                m_req_write;
  logic                      m_resp_valid;
  logic [7:0]                m_resp_data;

  logic                      snoop_valid;
  logic [1:0]                snoop_core;
  logic                      snoop_cmd;
  logic [ADDR_W-1:0]         snoop_addr;

  // Arbiter view: masters the memory port and the snoop bus.
  modport master (
    input  c_req_valid, c_req_we, c_req_addr, c_req_write,
    input  m_req_ready, m_resp_valid, m_resp_data,
    output c_req_ready, c_resp_valid, c_resp_data,
    output m_req_valid, m_req_we, m_req_addr, m_req_write,
    output snoop_valid, snoop_core, snoop_cmd, snoop_addr
  );

  // Environment view: caches, main memory and snoopers.
  modport slave (
    output c_req_valid, c_req_we, c_req_addr, c_req_write,
    output m_req_ready, m_resp_valid, m_resp_data,
    input  c_req_ready, c_resp_valid, c_resp_data,
    input  m_req_valid, m_req_we, m_req_addr, m_req_write,
    input  snoop_valid, snoop_core, snoop_cmd, snoop_addr
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin cache-to-memory arbiter with snoop broadcast
// One byte transaction at a time: grant, snoop, issue to memory, wait for response.
module mem_bus_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, GRANT, SNOOP, ISSUE, WAIT} state_t;

  state_t             state;
  logic [1:0]         last_grant;
  logic [1:0]         grant;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [7:0]         lat_write;

  logic               any_req;
  logic [1:0]         pick;
  logic [1:0]         idx;
  logic [N_CORES-1:0] pick_onehot;
  logic [N_CORES-1:0] grant_onehot;

  // Scan from farthest to nearest so the first requester after last_grant wins.
  always_comb begin
    any_req     = 1'b0;
    pick        = '0;
    idx         = '0;
    pick_onehot = '0;
    for (int k = N_CORES; k >= 1; k--) begin
      idx = 2'((int'(last_grant) + k) % N_CORES);
      if (bus.c_req_valid[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
    pick_onehot[pick] = any_req;
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N_CORES; i++) begin
      grant_onehot[i] = (grant == 2'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= 2'(N_CORES - 1);
      grant            <= '0;
      lat_we           <= 1'b0;
      lat_addr         <= '0;
      lat_write        <= '0;
      bus.c_req_ready  <= '0;
      bus.c_resp_valid <= '0;
      bus.c_resp_data  <= '0;
      bus.m_req_valid  <= 1'b0;
      bus.m_req_we     <= 1'b0;
      bus.m_req_addr   <= '0;
      bus.m_req_write  <= '0;
      bus.snoop_valid  <= 1'b0;
      bus.snoop_core   <= '0;
      bus.snoop_cmd    <= 1'b0;
      bus.snoop_addr   <= '0;
    end else begin
      bus.c_req_ready  <= '0;
      bus.c_resp_valid <= '0;
      bus.snoop_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant           <= pick;
            lat_we          <= bus.c_req_we[pick];
            lat_addr        <= bus.c_req_addr[int'(pick)*ADDR_W +: ADDR_W];
            lat_write       <= bus.c_req_write[int'(pick)*8 +: 8];
            bus.c_req_ready <= pick_onehot;
            state           <= GRANT;
          end
        end
        GRANT: begin
          bus.snoop_valid <= 1'b1;
          bus.snoop_core  <= grant;
          bus.snoop_cmd   <= lat_we;
          bus.snoop_addr  <= lat_addr;
          state           <= SNOOP;
        end
        SNOOP: begin
          bus.m_req_valid <= 1'b1;
          bus.m_req_we    <= lat_we;
          bus.m_req_addr  <= lat_addr;
          bus.m_req_write <= lat_write;
          state           <= ISSUE;
        end
        ISSUE: begin
          if (bus.m_req_ready) begin
            bus.m_req_valid <= 1'b0;
            // A memory that answers in the accept cycle completes right here.
            if (bus.m_resp_valid) begin
              bus.c_resp_valid <= grant_onehot;
              bus.c_resp_data  <= bus.m_resp_data;
              last_grant       <= grant;
              state            <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.m_resp_valid) begin
            bus.c_resp_valid <= grant_onehot;
            bus.c_resp_data  <= bus.m_resp_data;
            last_grant       <= grant;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int NC = 4;
  localparam int AW = 11;

  typedef struct {
    int         core;
    logic       we;
    logic [10:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         rdy_dly;
    int         rsp_dly;
    logic [3:0] exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.N_CORES(NC), .ADDR_W(AW)) bus();
  mem_bus_arbiter #(.N_CORES(NC), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {12'd0, bus.c_req_ready, bus.c_resp_valid, bus.c_resp_data, bus.m_req_valid,
            bus.m_req_we, bus.m_req_addr, bus.m_req_write, bus.snoop_valid, bus.snoop_core,
            bus.snoop_cmd, bus.snoop_addr};
  endfunction

  task automatic clear_inputs();
    bus.c_req_valid  = '0;
    bus.c_req_we     = '0;
    bus.c_req_addr   = '0;
    bus.c_req_write  = '0;
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b0;
    bus.m_resp_data  = '0;
  endtask

  task automatic set_req(input int core, input logic we, input logic [10:0] addr, input logic [7:0] wdata);
    bus.c_req_valid[core]          = 1'b1;
    bus.c_req_we[core]             = we;
    bus.c_req_addr[core*AW +: AW]  = addr;
    bus.c_req_write[core*8 +: 8]   = wdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    set_req(v.core, v.we, v.addr, v.wdata);
    @(negedge clk);
    check("ready_before_grant", bus.c_req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_pulse", bus.c_req_ready, v.exp_ready);
    check("mreq_during_grant", bus.m_req_valid, 0);
    @(posedge clk); #1;
    bus.c_req_valid[v.core] = 1'b0;
    @(negedge clk);
    check("snoop_valid", bus.snoop_valid, 1);
    check("snoop_core", bus.snoop_core, v.core);
    check("snoop_cmd", bus.snoop_cmd, v.we);
    check("snoop_addr", bus.snoop_addr, v.addr);
    check("ready_cleared", bus.c_req_ready, 0);
    check("mreq_during_snoop", bus.m_req_valid, 0);
    for (int d = 0; d <= v.rdy_dly; d++) begin
      @(posedge clk); #1;
      bus.m_req_ready  = (d == v.rdy_dly);
      bus.m_resp_valid = (d == v.rdy_dly) && (v.rsp_dly == 0);
      bus.m_resp_data  = v.rdata;
      @(negedge clk);
      check("issue_valid", bus.m_req_valid, 1);
      check("issue_fields", {bus.m_req_we, bus.m_req_addr, bus.m_req_write}, {v.we, v.addr, v.wdata});
      check("issue_no_snoop", bus.snoop_valid, 0);
    end
    for (int w = 1; w <= v.rsp_dly; w++) begin
      @(posedge clk); #1;
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = (w == v.rsp_dly);
      @(negedge clk);
      check("wait_mreq_low", bus.m_req_valid, 0);
      check("wait_no_resp", bus.c_resp_valid, 0);
    end
    @(posedge clk); #1;
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b0;
    bus.m_resp_data  = 8'h00;
    @(negedge clk);
    check("resp_pulse", bus.c_resp_valid, v.exp_ready);
    if (!v.we) check("resp_data", bus.c_resp_data, v.exp_data);
    check("resp_mreq_low", bus.m_req_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("resp_single", bus.c_resp_valid, 0);
    check("idle_no_ready", bus.c_req_ready, 0);
    if (!v.we) check("resp_data_hold", bus.c_resp_data, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    logic       found;
    logic [3:0] resp_seen;

    vecs[0] = '{core: 2, we: 1'b0, addr: 11'h155, wdata: 8'h00, rdata: 8'hA5, rdy_dly: 0, rsp_dly: 2, exp_ready: 4'b0100, exp_data: 8'hA5};
    vecs[1] = '{core: 1, we: 1'b1, addr: 11'h7FF, wdata: 8'h3C, rdata: 8'h00, rdy_dly: 0, rsp_dly: 1, exp_ready: 4'b0010, exp_data: 8'h00};
    vecs[2] = '{core: 3, we: 1'b0, addr: 11'h000, wdata: 8'h00, rdata: 8'h5A, rdy_dly: 5, rsp_dly: 1, exp_ready: 4'b1000, exp_data: 8'h5A};
    vecs[3] = '{core: 0, we: 1'b0, addr: 11'h2AA, wdata: 8'h00, rdata: 8'hC3, rdy_dly: 0, rsp_dly: 0, exp_ready: 4'b0001, exp_data: 8'hC3};
    vecs[4] = '{core: 1, we: 1'b1, addr: 11'h123, wdata: 8'hFF, rdata: 8'h00, rdy_dly: 2, rsp_dly: 0, exp_ready: 4'b0010, exp_data: 8'h00};

    clear_inputs();
    #1;
    check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outs(), 0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // All cores requesting continuously; memory always ready and answering.
    do_reset();
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 11'(16 * c + 1), 8'h00);
    bus.m_req_ready  = 1'b1;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 8'h77;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      cnt   = 0;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
        @(posedge clk); #1;
        @(negedge clk);
        cnt++;
        if (bus.c_req_ready != 0) found = 1'b1;
      end
      check("rr_found", found, 1);
      check("rr_grant", bus.c_req_ready, 4'b0001 << (g % NC));
      if (g > 0) check("rr_spacing", cnt, 4);
    end

    // Reset while waiting for memory, then check priority restarts at core 0.
    do_reset();
    @(posedge clk); #1;
    set_req(2, 1'b0, 11'h0F0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.c_req_valid[2] = 1'b0;
    @(posedge clk); #1;
    bus.m_req_ready = 1'b1;
    @(negedge clk);
    check("rst_issue_valid", bus.m_req_valid, 1);
    @(posedge clk); #1;
    bus.m_req_ready = 1'b0;
    @(negedge clk);
    check("rst_in_wait", bus.m_req_valid, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    set_req(0, 1'b0, 11'h011, 8'h00);
    set_req(3, 1'b0, 11'h033, 8'h00);
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 8'hEE;
    @(negedge clk);
    check("reset_held_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_grant", bus.c_req_ready, 4'b0001);
    check("post_reset_no_resp", bus.c_resp_valid, 0);
    @(posedge clk); #1;
    bus.c_req_valid[0] = 1'b0;
    bus.m_req_ready    = 1'b1;
    resp_seen = '0;
    found     = 1'b0;
    for (int cyc = 0; cyc < 8 && !found; cyc++) begin
      @(negedge clk);
      resp_seen = resp_seen | bus.c_resp_valid;
      if (bus.c_req_ready != 0) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("post_reset_second_found", found, 1);
    check("post_reset_second_grant", bus.c_req_ready, 4'b1000);
    check("post_reset_resp_seen", resp_seen, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
